iot_filter_engine: RTL and testbench

Parametrised streaming IoT data filter, successor of the fixed-format 128-bit/96-word filter in the sensor front end. It assembles narrow input beats into DATA_W-bit words and groups them into frames of FRAME_N words in groups of GROUP_N. It applies one of eight per-frame modes: pass, max, min, average, range extract, range exclude, peak-max and peak-min. Range thresholds are run-time ports rather than constants. It sits between the sensor byte stream and the result collector, and adds an end-of-frame strobe.

---
 rtl/iot_filter_engine_if.sv | 27 ++
 rtl/iot_filter_engine.sv | 214 +++++++++++++++++++++
 tb/tb_iot_filter_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iot_filter_engine_if.sv
// Beat-in / result-out bundle for iot_filter_engine.
// Latency: none, wires only.
// Backpressure: busy flows slave->master; beats offered while busy is high are dropped.
interface iot_filter_engine_if #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8
);
    logic              in_en;
    logic [IN_W-1:0]   iot_in;
    logic [2:0]        fn_sel;
    logic [DATA_W-1:0] thr_lo;
    logic [DATA_W-1:0] thr_hi;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] iot_out;
    logic              frame_done;

    modport master (
        output in_en, iot_in, fn_sel, thr_lo, thr_hi,
        input  busy, valid, iot_out, frame_done
    );

    modport slave (
        input  in_en, iot_in, fn_sel, thr_lo, thr_hi,
        output busy, valid, iot_out, frame_done
    );
endinterface

// File: rtl/iot_filter_engine.sv
// Streaming filter: assembles IN_W beats into DATA_W words, applies a per-frame mode per word/group.
// Latency: 2 edges from the last beat of a word to valid/iot_out/frame_done.
// Backpressure: busy stalls input for 2 cycles at each frame end; beats offered while busy are dropped.
module iot_filter_engine #(
    parameter int DATA_W  = 128,
    parameter int IN_W    = 8,
    parameter int GROUP_N = 8,
    parameter int FRAME_N = 96
) (
    input  logic               clk,
    input  logic               rst,
    iot_filter_engine_if.slave bus
);
    localparam int BEATS = DATA_W / IN_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LG    = $clog2(GROUP_N);
    localparam int WW    = $clog2(FRAME_N);
    localparam int AW    = DATA_W + LG;

    typedef enum logic [2:0] {
        M_PASS    = 3'b000,
        M_MAX     = 3'b001,
        M_MIN     = 3'b010,
        M_AVG     = 3'b011,
        M_EXTRACT = 3'b100,
        M_EXCLUDE = 3'b101,
        M_PMAX    = 3'b110,
        M_PMIN    = 3'b111
    } mode_e;

    // Assembly side
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WW-1:0]     asm_word_q, asm_word_d;
    // Hand-off to evaluation: sr_q holds the completed word while word_vld_q is high
    logic              word_vld_q, word_vld_d;
    logic [WW-1:0]     word_idx_q, word_idx_d;
    // Per-frame latched configuration
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    // Evaluation state
    logic [DATA_W-1:0] ext_q, ext_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              peak_have_q, peak_have_d;
    // Outputs
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              fdone_q, fdone_d;
    logic [DATA_W-1:0] out_q, out_d;

    // Combinational helpers
    logic              accept;
    logic              grp_last;
    logic              frm_last;
    logic              in_rng;
    logic              min_type;
    logic              emit;
    logic [LG-1:0]     pos;
    logic [DATA_W-1:0] cur_ext;
    logic [DATA_W-1:0] res;
    logic [AW-1:0]     cur_sum;

    // Next-state: beat assembly, frame-start latch, word evaluation and busy window
    always_comb begin
        sr_d        = sr_q;
        beat_d      = beat_q;
        asm_word_d  = asm_word_q;
        word_vld_d  = 1'b0;
        word_idx_d  = word_idx_q;
        mode_d      = mode_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        ext_d       = ext_q;
        acc_d       = acc_q;
        peak_d      = peak_q;
        peak_have_d = peak_have_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        fdone_d     = 1'b0;
        out_d       = out_q;
        emit        = 1'b0;
        res         = sr_q;

        accept   = bus.in_en && !busy_q;
        pos      = word_idx_q[LG-1:0];
        grp_last = (pos == LG'(GROUP_N - 1));
        frm_last = (word_idx_q == WW'(FRAME_N - 1));
        in_rng   = (sr_q >= lo_q) && (sr_q <= hi_q);
        min_type = (mode_q == M_MIN) || (mode_q == M_PMIN);

        // Running extreme and sum restart at group position 0 and include the current word
        if (pos == '0) begin
            cur_ext = sr_q;
        end else if (min_type) begin
            cur_ext = (sr_q < ext_q) ? sr_q : ext_q;
        end else begin
            cur_ext = (sr_q > ext_q) ? sr_q : ext_q;
        end
        cur_sum = (pos == '0) ? AW'(sr_q) : (acc_q + AW'(sr_q));

        // The stall ends on the edge after the frame's final result is registered
        if (fdone_q) begin
            busy_d = 1'b0;
        end

        if (word_vld_q) begin
            ext_d = cur_ext;
            acc_d = cur_sum;
            case (mode_q)
                M_PASS: begin
                    emit = 1'b1;
                    res  = sr_q;
                end
                M_MAX, M_MIN: begin
                    emit = grp_last;
                    res  = cur_ext;
                end
                M_AVG: begin
                    emit = grp_last;
                    res  = DATA_W'(cur_sum >> LG);
                end
                M_EXTRACT: emit = in_rng;
                M_EXCLUDE: emit = !in_rng;
                M_PMAX, M_PMIN: begin
                    // First group of a frame always wins; later ones only on a strict improvement
                    if (grp_last && (!peak_have_q ||
                        (min_type ? (cur_ext < peak_q) : (cur_ext > peak_q)))) begin
                        emit        = 1'b1;
                        res         = cur_ext;
                        peak_d      = cur_ext;
                        peak_have_d = 1'b1;
                    end
                end
                default: emit = 1'b0;
            endcase
            valid_d = emit;
            fdone_d = frm_last;
            if (emit) begin
                out_d = res;
            end
        end

        if (accept) begin
            sr_d = (sr_q << IN_W) | DATA_W'(bus.iot_in);
            // First beat of word 0 snapshots the configuration for the whole frame
            if (beat_q == '0 && asm_word_q == '0) begin
                mode_d      = mode_e'(bus.fn_sel);
                lo_d        = bus.thr_lo;
                hi_d        = bus.thr_hi;
                peak_d      = '0;
                peak_have_d = 1'b0;
            end
            if (beat_q == BW'(BEATS - 1)) begin
                beat_d     = '0;
                word_vld_d = 1'b1;
                word_idx_d = asm_word_q;
                if (asm_word_q == WW'(FRAME_N - 1)) begin
                    asm_word_d = '0;
                    busy_d     = 1'b1;
                end else begin
                    asm_word_d = asm_word_q + 1'b1;
                end
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q        <= '0;
            beat_q      <= '0;
            asm_word_q  <= '0;
            word_vld_q  <= 1'b0;
            word_idx_q  <= '0;
            mode_q      <= M_PASS;
            lo_q        <= '0;
            hi_q        <= '0;
            ext_q       <= '0;
            acc_q       <= '0;
            peak_q      <= '0;
            peak_have_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            fdone_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            sr_q        <= sr_d;
            beat_q      <= beat_d;
            asm_word_q  <= asm_word_d;
            word_vld_q  <= word_vld_d;
            word_idx_q  <= word_idx_d;
            mode_q      <= mode_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            ext_q       <= ext_d;
            acc_q       <= acc_d;
            peak_q      <= peak_d;
            peak_have_q <= peak_have_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            fdone_q     <= fdone_d;
            out_q       <= out_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.valid      = valid_q;
    assign bus.iot_out    = out_q;
    assign bus.frame_done = fdone_q;
endmodule

// File: tb/tb_iot_filter_engine.sv
// Bench for iot_filter_engine: default-parameter instance (a) and a 32/8/4/8 instance (b).
// Directed table plus hand sequences and randomized frames, checked against a frame-level model.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_iot_filter_engine;
    localparam logic [2:0] M_PASS = 3'd0, M_MAX = 3'd1, M_MIN = 3'd2, M_AVG = 3'd3;
    localparam logic [2:0] M_EXT = 3'd4, M_EXC = 3'd5, M_PMX = 3'd6, M_PMN = 3'd7;
    localparam int K_ASC = 0, K_AVG = 1, K_ONES = 2, K_RNG = 3, K_PK1 = 4, K_PK2 = 5, K_RAND = 6;
    localparam logic [127:0] T_LO = {8'h70, 120'h0};
    localparam logic [127:0] T_HI = {8'hAF, {120{1'b1}}};
    localparam logic [127:0] W_BELOW = {8'h6F, {120{1'b1}}};
    localparam logic [127:0] W_ABOVE = {8'hB0, 120'h0};

    typedef struct {
        logic [2:0]   mode;
        logic [127:0] lo;
        logic [127:0] hi;
        int           kind;
        int           exp_cnt;
        logic [127:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    iot_filter_engine_if #(.DATA_W(128), .IN_W(8)) a_if ();
    iot_filter_engine_if #(.DATA_W(32),  .IN_W(8)) b_if ();

    iot_filter_engine #(.DATA_W(128), .IN_W(8), .GROUP_N(8), .FRAME_N(96)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));
    iot_filter_engine #(.DATA_W(32), .IN_W(8), .GROUP_N(4), .FRAME_N(8)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] src_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] got_a[$];
    logic [127:0] got_b[$];
    int gotc_b[$];
    int lbq[$];
    int fd_a, fd_b, fdc_a, fdc_b, busyc_a, busyc_b, lb_cyc;
    int pk1 [12] = '{5, 5, 9, 3, 9, 12, 1, 1, 1, 1, 1, 1};
    vec_t tbl [11];

    // Output monitors
    always @(negedge clk) begin
        if (a_if.valid) got_a.push_back(a_if.iot_out);
        if (a_if.frame_done) begin fd_a++; fdc_a = cyc; end
        if (a_if.busy) busyc_a++;
        if (b_if.valid) begin got_b.push_back(128'(b_if.iot_out)); gotc_b.push_back(cyc); end
        if (b_if.frame_done) begin fd_b++; fdc_b = cyc; end
        if (b_if.busy) busyc_b++;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: busy never dropped", nm);
    endtask

    // Frame-level reference: outputs follow directly from the mode rules over the word list
    task automatic build_exp(input logic [2:0] md, input logic [127:0] lo, input logic [127:0] hi,
                             input int gn);
        logic [135:0] sum;
        logic [127:0] mx, mn, pk, w;
        bit have;
        exp_q.delete();
        have = 1'b0;
        pk = '0;
        foreach (src_q[i]) begin
            w = src_q[i];
            if (md == M_PASS) exp_q.push_back(w);
            if (md == M_EXT && w >= lo && w <= hi) exp_q.push_back(w);
            if (md == M_EXC && !(w >= lo && w <= hi)) exp_q.push_back(w);
        end
        for (int g = 0; g < src_q.size(); g += gn) begin
            sum = '0;
            mx = src_q[g];
            mn = src_q[g];
            for (int j = 0; j < gn; j++) begin
                w = src_q[g + j];
                sum = sum + 136'(w);
                if (w > mx) mx = w;
                if (w < mn) mn = w;
            end
            case (md)
                M_MAX: exp_q.push_back(mx);
                M_MIN: exp_q.push_back(mn);
                M_AVG: exp_q.push_back(128'(sum / 136'(gn)));
                M_PMX: if (!have || mx > pk) begin exp_q.push_back(mx); pk = mx; have = 1'b1; end
                M_PMN: if (!have || mn < pk) begin exp_q.push_back(mn); pk = mn; have = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic a_beats(input logic [127:0] w, input int nb, input int gmax);
        for (int k = 0; k < nb; k++) begin
            int guard;
            repeat ($urandom_range(0, gmax)) @(negedge clk);
            guard = 0;
            while (a_if.busy && guard < 20) begin @(negedge clk); guard++; end
            if (guard >= 20) timeout("a_wait");
            a_if.in_en  = 1'b1;
            a_if.iot_in = w[127 - 8*k -: 8];
            lb_cyc = cyc;
            @(negedge clk);
            a_if.in_en = 1'b0;
        end
    endtask

    task automatic b_beats(input logic [31:0] w, input int gmax);
        for (int k = 0; k < 4; k++) begin
            int guard;
            repeat ($urandom_range(0, gmax)) @(negedge clk);
            guard = 0;
            while (b_if.busy && guard < 20) begin @(negedge clk); guard++; end
            if (guard >= 20) timeout("b_wait");
            b_if.in_en  = 1'b1;
            b_if.iot_in = w[31 - 8*k -: 8];
            lb_cyc = cyc;
            @(negedge clk);
            b_if.in_en = 1'b0;
        end
    endtask

    task automatic build_a(input int kind);
        src_q.delete();
        for (int i = 0; i < 96; i++) begin
            logic [127:0] w;
            case (kind)
                K_ASC:  w = 128'(i + 1);
                K_AVG:  w = 128'(i % 8 + 1);
                K_ONES: w = '1;
                K_RNG:  case (i % 4)
                            0: w = W_BELOW;
                            1: w = T_LO;
                            2: w = T_HI;
                            default: w = W_ABOVE;
                        endcase
                K_PK1:  w = 128'(pk1[i / 8]);
                K_PK2:  w = 128'd2;
                default: w = {$urandom, $urandom, $urandom, $urandom};
            endcase
            src_q.push_back(w);
        end
    endtask

    task automatic run_a(input string nm, input logic [2:0] md, input logic [127:0] lo,
                         input logic [127:0] hi, input int gmax);
        got_a.delete();
        fd_a = 0;
        busyc_a = 0;
        a_if.fn_sel = md;
        a_if.thr_lo = lo;
        a_if.thr_hi = hi;
        foreach (src_q[i]) a_beats(src_q[i], 16, gmax);
        repeat (6) @(negedge clk);
        build_exp(md, lo, hi, 8);
        chki({nm, "_cnt"}, got_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) chk({nm, "_val"}, got_a[i], exp_q[i]);
        chki({nm, "_fdone"}, fd_a, 1);
        chki({nm, "_fd_lat"}, fdc_a - lb_cyc, 2);
        chki({nm, "_busy"}, busyc_a, 2);
    endtask

    task automatic build_b(input bit rnd, input logic [31:0] w0, input logic [31:0] w1);
        src_q.delete();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            if (rnd) w = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            else w = (i < 4) ? (w0 >> (8 * i)) & 32'hFF : (w1 >> (8 * (i - 4))) & 32'hFF;
            src_q.push_back(128'(w));
        end
    endtask

    task automatic run_b(input string nm, input logic [2:0] md, input logic [31:0] lo,
                         input logic [31:0] hi, input int chg, input bit hold, input int gmax);
        got_b.delete();
        gotc_b.delete();
        lbq.delete();
        fd_b = 0;
        busyc_b = 0;
        b_if.fn_sel = md;
        b_if.thr_lo = lo;
        b_if.thr_hi = hi;
        for (int i = 0; i < src_q.size(); i++) begin
            b_beats(src_q[i][31:0], gmax);
            lbq.push_back(lb_cyc);
            if (i == 0 && chg >= 0) begin
                b_if.fn_sel = 3'(chg);
                b_if.thr_lo = ~lo;
                b_if.thr_hi = ~hi;
            end
        end
        if (hold) begin
            int guard;
            guard = 0;
            b_if.in_en  = 1'b1;
            b_if.iot_in = 8'hA5;
            @(negedge clk);
            while (b_if.busy && guard < 10) begin @(negedge clk); guard++; end
            b_if.in_en = 1'b0;
        end
        repeat (5) @(negedge clk);
        build_exp(md, 128'(lo), 128'(hi), 4);
        chki({nm, "_cnt"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) chk({nm, "_val"}, got_b[i], exp_q[i]);
        chki({nm, "_fdone"}, fd_b, 1);
        chki({nm, "_fd_lat"}, fdc_b - lbq[7], 2);
        chki({nm, "_busy"}, busyc_b, 2);
        if (md == M_MAX || md == M_MIN || md == M_AVG) begin
            for (int k = 0; k < gotc_b.size() && k < 2; k++) chki({nm, "_lat"}, gotc_b[k], lbq[4*k + 3] + 2);
        end
        if (md == M_PASS) begin
            for (int k = 0; k < gotc_b.size() && k < 8; k++) chki({nm, "_lat"}, gotc_b[k], lbq[k] + 2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] wpre;
        tbl[0]  = '{M_MIN, '0, '0, K_ASC, 12, 128'd89};
        tbl[1]  = '{M_PASS, '0, '0, K_ASC, 96, 128'd96};
        tbl[2]  = '{M_AVG, '0, '0, K_AVG, 12, 128'd4};
        tbl[3]  = '{M_AVG, '0, '0, K_ONES, 12, {128{1'b1}}};
        tbl[4]  = '{M_EXT, T_LO, T_HI, K_RNG, 48, T_HI};
        tbl[5]  = '{M_EXC, T_LO, T_HI, K_RNG, 48, W_ABOVE};
        tbl[6]  = '{M_EXT, T_HI, T_LO, K_RNG, 0, W_ABOVE};
        tbl[7]  = '{M_EXC, T_HI, T_LO, K_RNG, 96, W_ABOVE};
        tbl[8]  = '{M_PMX, '0, '0, K_PK1, 3, 128'd12};
        tbl[9]  = '{M_PMX, '0, '0, K_PK2, 1, 128'd2};
        tbl[10] = '{M_PMN, '0, '0, K_PK1, 3, 128'd1};

        a_if.in_en = 1'b0; a_if.iot_in = '0; a_if.fn_sel = '0; a_if.thr_lo = '0; a_if.thr_hi = '0;
        b_if.in_en = 1'b0; b_if.iot_in = '0; b_if.fn_sel = '0; b_if.thr_lo = '0; b_if.thr_hi = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy_a", 128'(a_if.busy), 128'd0);
        chk("reset_valid_a", 128'(a_if.valid), 128'd0);
        chk("reset_out_a", a_if.iot_out, 128'd0);
        chk("reset_fdone_a", 128'(a_if.frame_done), 128'd0);
        chk("reset_busy_b", 128'(b_if.busy), 128'd0);
        chk("reset_out_b", 128'(b_if.iot_out), 128'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-word: pass three words, then 7 of 16 beats, then reset
        got_a.delete();
        a_if.fn_sel = M_PASS;
        wpre = '0;
        for (int i = 0; i < 3; i++) begin
            wpre = {4{32'hA5A5_0000 + 32'(i)}};
            a_beats(wpre, 16, 0);
        end
        a_beats({16{8'hC3}}, 7, 0);
        chki("pre_rst_cnt", got_a.size(), 3);
        chk("pre_rst_out", a_if.iot_out, wpre);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(a_if.busy), 128'd0);
        chk("rst_valid", 128'(a_if.valid), 128'd0);
        chk("rst_out", a_if.iot_out, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        build_a(K_ASC);
        run_a("rst_max", M_MAX, '0, '0, 0);
        chk("rst_max_first", (got_a.size() > 0) ? got_a[0] : '1, 128'd8);
        chki("rst_max_pulses", got_a.size(), 12);
        chk("rst_max_last", a_if.iot_out, 128'd96);

        // Directed frames on the default instance
        for (int t = 0; t < 11; t++) begin
            string nm;
            nm = $sformatf("tbl%0d", t);
            build_a(tbl[t].kind);
            run_a(nm, tbl[t].mode, tbl[t].lo, tbl[t].hi, t % 2);
            chki({nm, "_tcnt"}, got_a.size(), tbl[t].exp_cnt);
            chk({nm, "_hold"}, a_if.iot_out, tbl[t].exp_last);
        end

        // Randomized frames on the default instance
        for (int r = 0; r < 2; r++) begin
            build_a(K_RAND);
            run_a($sformatf("rnd_a%0d", r), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1);
        end

        // Small instance: mode change mid-frame ignored, min results 2 edges after last beat
        build_b(1'b0, 32'h0907_030A, 32'h1E0F_2814);
        run_b("b_min_chg", M_MIN, 32'd0, 32'd0, M_MAX, 1'b0, 0);
        chk("b_min_g0", (got_b.size() > 0) ? got_b[0] : '1, 128'd3);
        chk("b_min_g1", (got_b.size() > 1) ? got_b[1] : '1, 128'd15);

        // in_en held through busy: those beats must be dropped
        build_b(1'b1, 32'd0, 32'd0);
        run_b("b_hold", M_MIN, 32'd0, 32'd0, -1, 1'b1, 0);
        build_b(1'b0, 32'h0907_030A, 32'h1E0F_2814);
        run_b("b_after_hold", M_MAX, 32'd0, 32'd0, -1, 1'b0, 0);
        chk("b_max_g0", (got_b.size() > 0) ? got_b[0] : '1, 128'd10);
        chk("b_max_g1", (got_b.size() > 1) ? got_b[1] : '1, 128'd40);

        // Randomized frames on the small instance
        for (int r = 0; r < 30; r++) begin
            logic [31:0] lo, hi;
            lo = $urandom;
            hi = $urandom;
            build_b(1'b1, 32'd0, 32'd0);
            run_b($sformatf("rnd_b%0d", r), 3'($urandom_range(0, 7)), lo, hi,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1,
                  1'($urandom_range(0, 1)), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
